spi_cmd_seq: RTL and testbench

SPI_CMD_SEQ -- requirements
Module: spi_cmd_seq

---
 rtl/spi_cmd_seq.sv | 162 ++++++++++++++++
 tb/tb_spi_cmd_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_seq.sv
// Command FIFO plus sequencer that drives a strobe-based SPI master and returns read responses.
// Optional WAIT_RX timeout is enabled by defining SPI_CMD_SEQ_TIMEOUT_EN.
module spi_cmd_seq #(
   parameter int DATA_SIZE      = 16,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                          i_sys_clk,
   input  logic                          i_sys_rst,
   input  logic                          i_cmd_valid,
   output logic                          o_cmd_ready,
   input  logic [DATA_SIZE-1:0]          i_cmd_data,
   input  logic [1:0]                    i_cmd_addr,
   input  logic                          i_cmd_rd,
   output logic                          o_rsp_valid,
   input  logic                          i_rsp_ready,
   output logic [DATA_SIZE-1:0]          o_rsp_data,
   output logic                          o_rsp_timeout,
   output logic                          o_busy,
   output logic                          o_err,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
   output logic                          o_spi_csn,
   output logic                          o_spi_wr,
   output logic                          o_spi_rd,
   output logic [DATA_SIZE-1:0]          o_spi_data,
   output logic [1:0]                    o_spi_slave_addr,
   output logic                          o_spi_start,
   input  logic                          i_spi_tx_ready,
   input  logic                          i_spi_rx_ready,
   input  logic                          i_spi_tx_error,
   input  logic                          i_spi_rx_error,
   input  logic [DATA_SIZE-1:0]          i_spi_rx_data
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = DATA_SIZE + 3;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef SPI_CMD_SEQ_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_START   = 3'd2;
   localparam logic [2:0] S_WAIT_RX = 3'd3;
   localparam logic [2:0] S_READ    = 3'd4;
   localparam logic [2:0] S_CAPTURE = 3'd5;
   localparam logic [2:0] S_RSP     = 3'd6;

   logic [2:0]           state, state_nxt;
   logic [EW-1:0]        fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [LW-1:0]        level;
   logic                 full, empty, push, pop;
   logic [DATA_SIZE-1:0] cmd_data, rsp_data;
   logic [1:0]           cmd_addr;
   logic                 cmd_rd, rsp_timeout, err, tmo_hit;
   logic [TW-1:0]        tmo_cnt;
   logic                 tx_ready_unused;

   // The master's tx_ready is not needed: the sequence is paced by rx_ready alone.
   assign tx_ready_unused = i_spi_tx_ready;

   assign full  = (level == LW'(FIFO_DEPTH));
   assign empty = (level == '0);
   assign push  = i_cmd_valid && !full;
   assign pop   = (state == S_IDLE) && !empty;

   // NOTE: storage array carries no reset; validity is tracked solely by the pointers and level.
   always_ff @(posedge i_sys_clk) begin
      if (push) fifo_mem[wr_ptr] <= {i_cmd_data, i_cmd_addr, i_cmd_rd};
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // NOTE: default assignments first so no path through the case leaves a latch behind.
   always_comb begin
      state_nxt = state;
      tmo_hit   = 1'b0;
      case (state)
         S_IDLE:    if (!empty) state_nxt = S_LOAD;
         S_LOAD:    state_nxt = S_START;
         S_START:   state_nxt = S_WAIT_RX;
         S_WAIT_RX: begin
            if (i_spi_rx_ready) begin
               state_nxt = S_READ;
            end else if (TMO_EN && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1))) begin
               tmo_hit   = 1'b1;
               state_nxt = cmd_rd ? S_RSP : S_IDLE;
            end
         end
         S_READ:    state_nxt = S_CAPTURE;
         S_CAPTURE: state_nxt = cmd_rd ? S_RSP : S_IDLE;
         S_RSP:     if (i_rsp_ready) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         state       <= S_IDLE;
         cmd_data    <= '0;
         cmd_addr    <= '0;
         cmd_rd      <= 1'b0;
         rsp_data    <= '0;
         rsp_timeout <= 1'b0;
         err         <= 1'b0;
         tmo_cnt     <= '0;
      end else begin
         state <= state_nxt;
         if (pop) begin
            {cmd_data, cmd_addr, cmd_rd} <= fifo_mem[rd_ptr];
            rsp_timeout                  <= 1'b0;
         end
         if (state == S_START)        tmo_cnt <= '0;
         else if (state == S_WAIT_RX) tmo_cnt <= tmo_cnt + 1'b1;
         // Master returns read data one cycle after the READ strobe.
         if (state == S_CAPTURE) begin
            rsp_data    <= i_spi_rx_data;
            rsp_timeout <= 1'b0;
         end else if (tmo_hit && cmd_rd) begin
            rsp_data    <= '0;
            rsp_timeout <= 1'b1;
         end
         if ((state != S_IDLE) && (i_spi_tx_error || i_spi_rx_error)) err <= 1'b1;
      end
   end

   assign o_cmd_ready      = !full;
   assign o_fifo_level     = level;
   assign o_busy           = (state != S_IDLE) || !empty;
   assign o_err            = err;
   assign o_rsp_valid      = (state == S_RSP);
   assign o_rsp_data       = rsp_data;
   assign o_rsp_timeout    = TMO_EN ? rsp_timeout : 1'b0;
   assign o_spi_csn        = !((state == S_LOAD) || (state == S_READ));
   assign o_spi_wr         = (state == S_LOAD);
   assign o_spi_rd         = (state == S_READ);
   assign o_spi_start      = (state == S_START) || (state == S_WAIT_RX);
   assign o_spi_data       = cmd_data;
   assign o_spi_slave_addr = cmd_addr;

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Directed self-checking bench for spi_cmd_seq; the timeout scenario runs only when
// SPI_CMD_SEQ_TIMEOUT_EN is defined (the DUT is built with TIMEOUT_CYCLES=20).
module tb_spi_cmd_seq;

   localparam int DW  = 16;
   localparam int FD  = 4;
   localparam int TMO = 20;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_rd;
   logic [DW-1:0] cmd_data;
   logic [1:0]    cmd_addr;
   logic          rsp_valid, rsp_ready, rsp_timeout;
   logic [DW-1:0] rsp_data;
   logic          busy, err;
   logic [2:0]    fifo_level;
   logic          spi_csn, spi_wr, spi_rd, spi_start;
   logic [DW-1:0] spi_data;
   logic [1:0]    spi_addr;
   logic          tx_ready, rx_ready, tx_error, rx_error;
   logic [DW-1:0] rx_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   spi_cmd_seq #(.DATA_SIZE(DW), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TMO)) dut (
      .i_sys_clk(clk), .i_sys_rst(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_data(cmd_data),
      .i_cmd_addr(cmd_addr), .i_cmd_rd(cmd_rd),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
      .o_rsp_timeout(rsp_timeout), .o_busy(busy), .o_err(err), .o_fifo_level(fifo_level),
      .o_spi_csn(spi_csn), .o_spi_wr(spi_wr), .o_spi_rd(spi_rd), .o_spi_data(spi_data),
      .o_spi_slave_addr(spi_addr), .o_spi_start(spi_start),
      .i_spi_tx_ready(tx_ready), .i_spi_rx_ready(rx_ready), .i_spi_tx_error(tx_error),
      .i_spi_rx_error(rx_error), .i_spi_rx_data(rx_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [DW-1:0] d, input logic [1:0] a, input logic r);
      int guard = 0;
      cmd_valid = 1'b1;
      cmd_data  = d;
      cmd_addr  = a;
      cmd_rd    = r;
      while (!cmd_ready && guard < 200) begin
         step();
         guard++;
      end
      check("push_accept_in_time", guard < 200, 1);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int guard = 0;
      while (busy && guard < 300) begin
         step();
         guard++;
      end
      check(tag, guard < 300, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int load_cnt, start_cnt, read_cnt, rsp_seen, k, g, bad, n_ld;
   logic [DW-1:0] load_data;
   logic [1:0]    load_addr;
   logic          loaded, pre_ready;
   logic [DW-1:0] c_data [5];
   logic [1:0]    c_addr [5];
   logic [DW-1:0] ld_data [8];
   logic [1:0]    ld_addr [8];

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_addr = '0; cmd_rd = 1'b0;
      rsp_ready = 1'b0; tx_ready = 1'b1; rx_ready = 1'b0; tx_error = 1'b0; rx_error = 1'b0;
      rx_data = '0;
      c_data = '{16'hC001, 16'hC002, 16'hC003, 16'hC004, 16'hC005};
      c_addr = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      step(); step(); step();

      // Reset state
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_level", fifo_level, 0);
      check("rst_rsp", {rsp_valid, rsp_timeout, err, busy}, 4'b0000);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_spi_strobes", {spi_csn, spi_wr, spi_rd, spi_start}, 4'b1000);
      check("rst_spi_data_addr", {spi_data, spi_addr}, 0);
      rst = 1'b0;
      step();

      // Write command, rx_ready arrives on the 10th WAIT_RX cycle
      rx_data = 16'hBEEF;
      push_cmd(16'hA55A, 2'd2, 1'b0);
      load_cnt = 0; start_cnt = 0; read_cnt = 0; rsp_seen = 0;
      load_data = '0; load_addr = '0;
      for (int i = 0; i < 40; i++) begin
         if (spi_wr && !spi_csn) begin
            load_cnt++;
            load_data = spi_data;
            load_addr = spi_addr;
         end
         if (spi_start) begin
            start_cnt++;
            if (start_cnt == 11) rx_ready = 1'b1;
         end
         if (spi_rd && !spi_csn) begin
            read_cnt++;
            rx_ready = 1'b0;
         end
         if (rsp_valid) rsp_seen++;
         step();
      end
      check("wr_load_pulses", load_cnt, 1);
      check("wr_load_data", load_data, 16'hA55A);
      check("wr_load_addr", load_addr, 2);
      check("wr_start_cycles", start_cnt, 11);
      check("wr_read_pulses", read_cnt, 1);
      check("wr_no_response", rsp_seen, 0);
      check("wr_idle_after", busy, 0);

      // Read command with response back-pressure
      rx_data  = 16'h1234;
      rx_ready = 1'b1;
      push_cmd(16'h0001, 2'd1, 1'b1);
      k = 0; g = 0; loaded = 1'b0;
      while (!rsp_valid && g < 30) begin
         if (spi_wr) loaded = 1'b1;
         if (loaded) k++;
         step();
         g++;
      end
      rx_ready = 1'b0;
      // pop cycle + LOAD..CAPTURE: 5 plus one WAIT_RX cycle
      check("rd_latency", k + 1, 6);
      check("rd_rsp_valid", rsp_valid, 1);
      check("rd_rsp_data", rsp_data, 16'h1234);
      check("rd_rsp_timeout", rsp_timeout, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("rd_hold_valid", rsp_valid, 1);
         check("rd_hold_data", rsp_data, 16'h1234);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("rd_valid_drop", rsp_valid, 0);

      // Simultaneous push/pop, then sticky error
      cmd_valid = 1'b1; cmd_data = 16'h1111; cmd_addr = 2'd1; cmd_rd = 1'b0;
      step();
      cmd_data = 16'h2222; cmd_addr = 2'd2;
      step();
      cmd_valid = 1'b0;
      check("push_pop_level", fifo_level, 1);
      step(); step();
      tx_error = 1'b1;
      step();
      tx_error = 1'b0;
      check("err_set", err, 1);
      check("err_seq_continues", spi_start, 1);
      rx_ready = 1'b1;
      wait_idle("err_drain_in_time");
      rx_ready = 1'b0;
      check("err_sticky", err, 1);
      check("err_drain_level", fifo_level, 0);

      // Reset during WAIT_RX with two entries queued
      cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_addr = 2'd3; cmd_data = 16'h3333;
      step();
      cmd_data = 16'h4444;
      step();
      cmd_data = 16'h5555;
      step();
      cmd_valid = 1'b0; cmd_rd = 1'b0;
      step();
      check("mid_pre_level", fifo_level, 2);
      check("mid_pre_start", spi_start, 1);
      rst = 1'b1;
      step();
      check("mid_start_low", spi_start, 0);
      check("mid_level_zero", fifo_level, 0);
      check("mid_idle", busy, 0);
      check("mid_err_cleared", err, 0);
      check("mid_strobes", {spi_csn, spi_wr, spi_rd, rsp_valid}, 4'b1000);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (rsp_valid || spi_wr) bad++;
      end
      check("mid_no_activity", bad, 0);

      // FIFO fill with SPI stalled, in-order issue across pointer wrap
      push_cmd(16'h0F0F, 2'd3, 1'b0);
      g = 0;
      while (!spi_start && g < 20) begin
         step();
         g++;
      end
      check("fill_stall_reached", spi_start, 1);
      for (int i = 0; i < 4; i++) begin
         cmd_valid = 1'b1; cmd_data = c_data[i]; cmd_addr = c_addr[i]; cmd_rd = 1'b0;
         step();
      end
      cmd_data = c_data[4]; cmd_addr = c_addr[4];
      check("fill_level_4", fifo_level, 4);
      check("fill_ready_low", cmd_ready, 0);
      step(); step(); step();
      check("fill_held_level", fifo_level, 4);
      check("fill_held_ready", cmd_ready, 0);
      rx_ready = 1'b1;
      n_ld = 0; g = 0;
      while ((n_ld < 5 || busy || cmd_valid) && g < 200) begin
         pre_ready = cmd_ready;
         if (spi_wr && n_ld < 8) begin
            ld_data[n_ld] = spi_data;
            ld_addr[n_ld] = spi_addr;
            n_ld++;
         end
         step();
         if (cmd_valid && pre_ready) cmd_valid = 1'b0;
         g++;
      end
      rx_ready = 1'b0;
      check("fill_issue_count", n_ld, 5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("fill_order_addr%0d", i), ld_addr[i], c_addr[i]);
         check($sformatf("fill_order_data%0d", i), ld_data[i], c_data[i]);
      end
      check("fill_level_empty", fifo_level, 0);
      check("fill_ready_back", cmd_ready, 1);

`ifdef SPI_CMD_SEQ_TIMEOUT_EN
      // WAIT_RX timeout on a read
      rx_data = 16'hFFFF;
      push_cmd(16'h7777, 2'd2, 1'b1);
      start_cnt = 0; g = 0;
      while (!rsp_valid && g < 100) begin
         if (spi_start) start_cnt++;
         step();
         g++;
      end
      check("tmo_start_cycles", start_cnt, 1 + TMO);
      check("tmo_rsp_valid", rsp_valid, 1);
      check("tmo_flag", rsp_timeout, 1);
      check("tmo_rsp_data", rsp_data, 0);
      check("tmo_start_low", spi_start, 0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("tmo_valid_drop", rsp_valid, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
